// File: rtl/hazard_stall_if.sv
// Signal bundle between the MIPS pipeline and the hazard/stall controller.
// The master side is the datapath (supplies stage fields); the slave side is the controller.
interface hazard_stall_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic             ID_Branch;
    logic             ID_BranchTaken;
    logic             ID_Jump;
    logic             ID_MulDiv;
    logic             ID_ReadHiLo;
    logic             EX_MemRead;
    logic             EX_RegWrite;
    logic [4:0]       EX_Rd;
    logic             MEM_MemRead;
    logic [4:0]       MEM_Rd;
    logic             PCStall;
    logic             IFIDStall;
    logic             IFIDFlush;
    logic             IDEXBubble;
    logic             MDBusy;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_MulDiv, ID_ReadHiLo, EX_MemRead, EX_RegWrite, EX_Rd,
               MEM_MemRead, MEM_Rd,
        input  PCStall, IFIDStall, IFIDFlush, IDEXBubble, MDBusy, StallCycles
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Jump,
               ID_MulDiv, ID_ReadHiLo, EX_MemRead, EX_RegWrite, EX_Rd,
               MEM_MemRead, MEM_Rd,
        output PCStall, IFIDStall, IFIDFlush, IDEXBubble, MDBusy, StallCycles
    );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / branch-operand / mul-div hazard detection for the 5-stage MIPS pipeline,
// with a mul/div busy sequencer and a saturating stall-cycle counter.
module hazard_stall_controller #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input logic          Clk,
    input logic          Reset,
    hazard_stall_if.slave bus
);
    typedef enum logic {RUN, MD_BUSY} state_e;

    localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 1);

    state_e           state_q;
    logic [3:0]       md_count_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall;
    logic             flush;

    function automatic logic src_hit(input logic [4:0] rd, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic uses_rt);
        return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
    endfunction

    // Hazards are combinational so the stall lands in the same cycle it becomes visible;
    // gating with Reset keeps every output quiet while reset is held.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        stall = 1'b0;
        flush = 1'b0;
        if (Reset) begin
            stall = (bus.EX_MemRead &&
                     src_hit(bus.EX_Rd, bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRt))
                 || (bus.ID_Branch && bus.EX_RegWrite && !bus.EX_MemRead &&
                     src_hit(bus.EX_Rd, bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRt))
                 || (bus.ID_Branch && bus.MEM_MemRead &&
                     src_hit(bus.MEM_Rd, bus.ID_Rs, bus.ID_Rt, bus.ID_UsesRt))
                 || ((state_q == MD_BUSY) && (bus.ID_ReadHiLo || bus.ID_MulDiv));
            flush = !stall && ((bus.ID_Branch && bus.ID_BranchTaken) || bus.ID_Jump);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= RUN;
            md_count_q <= 4'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            case (state_q)
                RUN: begin
                    if (bus.ID_MulDiv && !stall) begin
                        state_q    <= MD_BUSY;
                        md_count_q <= MD_LOAD;
                    end
                end
                MD_BUSY: begin
                    if (md_count_q == 4'd0) state_q <= RUN;
                    else                    md_count_q <= md_count_q - 4'd1;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)                     cnt_q <= '0;
        else if (stall && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
    end

    assign bus.PCStall     = stall;
    assign bus.IFIDStall   = stall;
    assign bus.IDEXBubble  = stall;
    assign bus.IFIDFlush   = flush;
    assign bus.MDBusy      = (state_q == MD_BUSY);
    assign bus.StallCycles = cnt_q;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: stimulus pushes model predictions each cycle; a negedge monitor
// pops and compares them against the controller outputs.
module tb_hazard_stall_controller;
    localparam int LAT   = 4;
    localparam int CW    = 4;
    localparam int C_MAX = (1 << CW) - 1;

    typedef struct {
        bit       rst_n;
        bit [4:0] rs, rt;
        bit       uses_rt, branch, taken, jump, muldiv, readhilo;
        bit       ex_mr, ex_rw;
        bit [4:0] ex_rd;
        bit       mem_mr;
        bit [4:0] mem_rd;
    } stim_t;

    typedef struct {
        bit stall;
        bit flush;
        bit busy;
        int cnt;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    hazard_stall_if #(.CNT_W(CW)) bus ();

    hazard_stall_controller #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stim_done = 1'b0;

    // Reference model state: remaining busy cycles of the mul/div unit and stall total.
    int busy_left = 0;
    int stall_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit uses_reg(input bit [4:0] rd, input stim_t s);
        return rd != 0 && (rd == s.rs || (s.uses_rt && rd == s.rt));
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{rst_n: 1'b1, default: '0};
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   load_use, alu_to_branch, load_to_branch, hilo_wait;
        Reset              = s.rst_n;
        bus.ID_Rs          = s.rs;
        bus.ID_Rt          = s.rt;
        bus.ID_UsesRt      = s.uses_rt;
        bus.ID_Branch      = s.branch;
        bus.ID_BranchTaken = s.taken;
        bus.ID_Jump        = s.jump;
        bus.ID_MulDiv      = s.muldiv;
        bus.ID_ReadHiLo    = s.readhilo;
        bus.EX_MemRead     = s.ex_mr;
        bus.EX_RegWrite    = s.ex_rw;
        bus.EX_Rd          = s.ex_rd;
        bus.MEM_MemRead    = s.mem_mr;
        bus.MEM_Rd         = s.mem_rd;
        if (!s.rst_n) begin
            busy_left   = 0;
            stall_total = 0;
        end
        load_use       = s.ex_mr && uses_reg(s.ex_rd, s);
        alu_to_branch  = s.branch && s.ex_rw && !s.ex_mr && uses_reg(s.ex_rd, s);
        load_to_branch = s.branch && s.mem_mr && uses_reg(s.mem_rd, s);
        hilo_wait      = busy_left > 0 && (s.readhilo || s.muldiv);
        e.stall = s.rst_n && (load_use || alu_to_branch || load_to_branch || hilo_wait);
        e.flush = s.rst_n && !e.stall && ((s.branch && s.taken) || s.jump);
        e.busy  = busy_left > 0;
        e.cnt   = stall_total;
        exp_q.push_back(e);
        @(posedge Clk);
        if (s.rst_n) begin
            if (e.stall && stall_total < C_MAX) stall_total++;
            if (busy_left > 0)                   busy_left--;
            else if (s.muldiv && !e.stall)       busy_left = LAT;
        end
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("PCStall",     32'(bus.PCStall),     32'(e.stall));
                check("IFIDStall",   32'(bus.IFIDStall),   32'(e.stall));
                check("IDEXBubble",  32'(bus.IDEXBubble),  32'(e.stall));
                check("IFIDFlush",   32'(bus.IFIDFlush),   32'(e.flush));
                check("MDBusy",      32'(bus.MDBusy),      32'(e.busy));
                check("StallCycles", 32'(bus.StallCycles), 32'(e.cnt));
            end
        end
    end

    function automatic bit [4:0] pick_reg();
        bit [4:0] tbl [4];
        tbl = '{5'd0, 5'd8, 5'd9, 5'd10};
        if ($urandom_range(0, 4) == 0) return 5'($urandom);
        return tbl[$urandom_range(0, 3)];
    endfunction

    initial begin : stimulus
        stim_t s;
        int    wait_cycles;
        Reset = 1'b0;
        @(posedge Clk);
        #1;

        // Reset held with a live load-use pattern, then released with the same pattern.
        s = nop(); s.rst_n = 0; s.ex_mr = 1; s.ex_rd = 8; s.rs = 8;
        step(s);
        s.rst_n = 1;
        step(s);
        step(nop());

        // Load-use on $8, then the same with $0 as destination.
        s = nop(); s.ex_mr = 1; s.ex_rd = 8; s.rs = 8; step(s);
        step(nop());
        s = nop(); s.ex_mr = 1; s.ex_rd = 0; s.rs = 0; step(s);

        // lw $9 ; beq $9,$10 : LU, then BD2, then taken branch flushes.
        s = nop(); s.ex_mr = 1; s.ex_rd = 9; s.rs = 9; s.rt = 10; s.uses_rt = 1; s.branch = 1;
        step(s);
        s.ex_mr = 0; s.ex_rd = 0; s.mem_mr = 1; s.mem_rd = 9; step(s);
        s.mem_mr = 0; s.mem_rd = 0; s.taken = 1; step(s);

        // Jump with no hazard; taken branch blocked by an ALU dependence.
        s = nop(); s.jump = 1; step(s);
        s = nop(); s.branch = 1; s.taken = 1; s.rs = 10; s.ex_rw = 1; s.ex_rd = 10; step(s);

        // mult issues, mflo waits for the busy window, then proceeds.
        s = nop(); s.muldiv = 1; step(s);
        s = nop(); s.readhilo = 1;
        for (int i = 0; i < LAT + 1; i++) step(s);
        // Back-to-back mul/div: the second one waits, then issues in the first RUN cycle.
        s = nop(); s.muldiv = 1;
        for (int i = 0; i < LAT + 2; i++) step(s);

        // Drive the counter to saturation and hold the stall beyond it.
        s = nop(); s.ex_mr = 1; s.ex_rd = 8; s.rs = 8;
        for (int i = 0; i < C_MAX + 3; i++) step(s);

        // Reset in the middle of a busy window.
        s = nop(); s.muldiv = 1; step(s);
        step(nop());
        s = nop(); s.rst_n = 0; step(s);
        step(nop());

        // Randomized traffic biased toward register collisions.
        for (int i = 0; i < 600; i++) begin
            s.rst_n    = ($urandom_range(0, 59) != 0);
            s.rs       = pick_reg();
            s.rt       = pick_reg();
            s.uses_rt  = 1'($urandom);
            s.branch   = ($urandom_range(0, 2) == 0);
            s.taken    = 1'($urandom);
            s.jump     = ($urandom_range(0, 5) == 0);
            s.muldiv   = ($urandom_range(0, 5) == 0);
            s.readhilo = ($urandom_range(0, 3) == 0);
            s.ex_mr    = ($urandom_range(0, 2) == 0);
            s.ex_rw    = 1'($urandom);
            s.ex_rd    = pick_reg();
            s.mem_mr   = ($urandom_range(0, 2) == 0);
            s.mem_rd   = pick_reg();
            step(s);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge Clk);
            wait_cycles++;
        end
        n_checks++;
        if (exp_q.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
Pipeline hazard controller for the 5-stage MIPS datapath. It generates the Stall input for ProgramCounter and the IF/ID register, inserts ID/EX bubbles, and flushes IF/ID on taken branches and jumps. It also sequences the multi-cycle mul/div unit's busy window and keeps a saturating stall-cycle performance counter.

Parameters:
MD_LATENCY, 4, cycles the mul/div unit stays busy after issue (legal range 1..15)
CNT_W, 32, width of the StallCycles performance counter

Ports:
Clk  input  1  system clock, rising-edge
Reset  input  1  asynchronous, active-low; 0 = reset
ID_Rs  input  5  rs field of the instruction in ID
ID_Rt  input  5  rt field of the instruction in ID
ID_UsesRt  input  1  ID instruction reads rt as a source
ID_Branch  input  1  ID instruction is beq/bne (compares in ID)
ID_BranchTaken  input  1  ID comparator result; valid only when operands are ready
ID_Jump  input  1  ID instruction is j/jal/jr
ID_MulDiv  input  1  ID instruction is mult/div
ID_ReadHiLo  input  1  ID instruction is mfhi/mflo
EX_MemRead  input  1  EX instruction is a load
EX_RegWrite  input  1  EX instruction writes a register
EX_Rd  input  5  destination register of the EX instruction
MEM_MemRead  input  1  MEM instruction is a load
MEM_Rd  input  5  destination register of the MEM instruction
PCStall  output  1  hold the PC (drives ProgramCounter Stall)
IFIDStall  output  1  hold the IF/ID register
IFIDFlush  output  1  zero the IF/ID register at the next edge
IDEXBubble  output  1  load a NOP into ID/EX at the next edge
MDBusy  output  1  mul/div unit busy
StallCycles  output  CNT_W  count of cycles with PCStall=1; saturates

Behaviour:
- State is registered and clears asynchronously when Reset=0. Reset state: FSM=RUN, MDCount=0, StallCycles=0.
- While Reset=0, all outputs are 0.
- Hazard terms are combinational from the current inputs and state. Register 0 never matches any hazard term.
  - srcHit(rd) = (rd!=0) & (rd==ID_Rs | (ID_UsesRt & rd==ID_Rt))
  - LU (load-use) = EX_MemRead & srcHit(EX_Rd)
  - BD1 = ID_Branch & EX_RegWrite & !EX_MemRead & srcHit(EX_Rd)
  - BD2 = ID_Branch & MEM_MemRead & srcHit(MEM_Rd)
  - MDH = (FSM==MD_BUSY) & (ID_ReadHiLo | ID_MulDiv)
- stall = LU | BD1 | BD2 | MDH.
- PCStall = IFIDStall = IDEXBubble = stall. This gives a zero-latency response in the cycle the hazard is visible.
- Resulting stall lengths:
  - Load followed by a dependent ALU op: exactly 1 stall cycle.
  - ALU op followed by a dependent branch: 1 stall cycle.
  - Load followed by a dependent branch: 2 stall cycles (LU, then BD2).
- IFIDFlush = !stall & ((ID_Branch & ID_BranchTaken) | ID_Jump).
  - A flush is never asserted while stalling, because branch operands are not ready.
  - Flush and stall are mutually exclusive by construction.
- FSM states: RUN, MD_BUSY.
  - RUN -> MD_BUSY when ID_MulDiv & !stall (the op issues). MDCount loads MD_LATENCY-1.
  - In MD_BUSY, MDCount decrements each cycle. At MDCount==0 -> RUN on the next edge.
  - A mul/div in ID during MD_BUSY stalls. It issues in the first RUN cycle; there is no back-to-back issue.
  - With MD_LATENCY=1, MD_BUSY lasts exactly one cycle.
- MDBusy = (FSM==MD_BUSY).
- StallCycles increments at each rising edge where PCStall=1. It holds at 2^CNT_W-1 and never wraps.
- Asserting Reset mid-operation aborts MD_BUSY immediately. Any pending stall or flush is dropped that cycle.
- Reset deassertion is synchronous to Clk by the system; the first active edge resumes in RUN.

Test Plan:
- Reset=0 with LU inputs active (EX_MemRead=1, EX_Rd=8, ID_Rs=8) -> all outputs 0. Release Reset -> PCStall=1 that cycle, and StallCycles=1 after the edge.
- lw $8 in EX, add using $8 in ID -> PCStall=IFIDStall=IDEXBubble=1 for exactly 1 cycle. Then 0, with StallCycles +1. Repeat with EX_Rd=0 -> no stall.
- lw $9 then beq $9,$10 -> stall for 2 consecutive cycles (LU, then BD2 with MEM_Rd=9). In the third cycle, ID_BranchTaken=1 -> IFIDFlush=1 for 1 cycle, PCStall=0.
- ID_Jump=1 with no hazard -> IFIDFlush=1, PCStall=0. ID_Branch=1, ID_BranchTaken=1 together with BD1 true -> IFIDFlush=0, PCStall=1.
- MD_LATENCY=4: issue mult, then mflo in ID on the next cycle -> MDBusy=1 for 4 cycles and mflo stalls all 4. Mflo proceeds on cycle 5; StallCycles=4.
- Preload StallCycles near saturation (CNT_W=4, 15 counts) and hold a stall for 3 more cycles -> StallCycles stays at 15. Assert Reset during MD_BUSY -> MDBusy=0 immediately and the counter clears to 0.
